packed_result_unpacker: RTL and testbench

PACKED_RESULT_UNPACKER -- requirements
Module: packed_result_unpacker

---
 rtl/packed_result_unpacker.sv | 119 +++++++++++
 tb/tb_packed_result_unpacker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_result_unpacker.sv
// rtl/packed_result_unpacker.sv - splits packed signed result words into sign-extended output beats
// Optional feature macro: UNPACK_BEAT_COUNT_EN adds a 16-bit output beat counter port.
module packed_result_unpacker #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 choose_8bit,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_lane,
    output logic                 out_last
`ifdef UNPACK_BEAT_COUNT_EN
    ,
    output logic [15:0]          beat_count
`endif
);

    localparam int HALF = IN_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_LO = 2'd1,
        EMIT_HI = 2'd2
    } state_t;

    state_t               state;
    logic [HALF-1:0]      hold_hi;
    logic                 hold_mode;
    logic                 in_xfer;
    logic                 out_xfer;
    logic [OUT_WIDTH-1:0] first_beat;
    logic [OUT_WIDTH-1:0] hi_beat;

    // Accept a new word when idle, or when the final beat of the current word leaves this cycle.
    always_comb begin
        in_ready = reset && ((state == IDLE) || (out_last && out_ready));
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
    end

    // First beat comes straight from the incoming word; the high lane comes from the held half.
    always_comb begin
        first_beat = '0;
        if (choose_8bit) begin
            first_beat = OUT_WIDTH'($signed(in_data[HALF-1:0]));
        end else begin
            first_beat = OUT_WIDTH'($signed(in_data));
        end
        hi_beat = OUT_WIDTH'($signed(hold_hi));
    end

    // Beat sequencer with registered outputs; a new capture always restarts at the low/full beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= 1'b0;
            out_last  <= 1'b0;
            hold_hi   <= '0;
            hold_mode <= 1'b0;
        end else if (in_xfer) begin
            state     <= EMIT_LO;
            hold_hi   <= in_data[IN_WIDTH-1:HALF];
            hold_mode <= choose_8bit;
            out_valid <= 1'b1;
            out_data  <= first_beat;
            out_lane  <= 1'b0;
            out_last  <= !choose_8bit;
        end else begin
            case (state)
                EMIT_LO: begin
                    if (out_ready) begin
                        if (hold_mode) begin
                            state    <= EMIT_HI;
                            out_data <= hi_beat;
                            out_lane <= 1'b1;
                            out_last <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                EMIT_HI: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef UNPACK_BEAT_COUNT_EN
    // Free-running count of accepted output beats, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_count <= 16'd0;
        end else if (out_xfer) begin
            beat_count <= beat_count + 16'd1;
        end
    end
`else
    logic unused_xfer;
    always_comb unused_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_packed_result_unpacker.sv
// tb/tb_packed_result_unpacker.sv - randomized and directed checks against a queue-based beat model
module tb_packed_result_unpacker;

    logic        clk;
    logic        rst_n;
    logic        choose;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_lane;
    logic        out_last;
`ifdef UNPACK_BEAT_COUNT_EN
    logic [15:0] beat_count;
    logic [15:0] exp_cnt;
`endif

    int checks;
    int errors;
    bit chk_en;

    typedef struct {
        logic [31:0] d;
        logic        lane;
        logic        last;
    } beat_t;

    beat_t q[$];

    packed_result_unpacker #(
        .IN_WIDTH (32),
        .OUT_WIDTH(32)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .choose_8bit(choose),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_last   (out_last)
`ifdef UNPACK_BEAT_COUNT_EN
        ,
        .beat_count (beat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext_half(input logic [15:0] v);
        int t;
        t = int'(v);
        if (t >= 32768) t = t - 65536;
        return t;
    endfunction

    function automatic bit exp_ready();
        return rst_n && ((q.size() == 0) || (q[0].last && out_ready));
    endfunction

    // Reference model: every accepted word expands into its list of beats.
    always @(posedge clk) begin
        bit ov;
        bit ir;
        beat_t b;
        if (!rst_n) begin
            q.delete();
`ifdef UNPACK_BEAT_COUNT_EN
            exp_cnt = 16'd0;
`endif
        end else begin
            ov = (q.size() != 0);
            ir = exp_ready();
            if (ov && out_ready) begin
                void'(q.pop_front());
`ifdef UNPACK_BEAT_COUNT_EN
                exp_cnt = exp_cnt + 16'd1;
`endif
            end
            if (in_valid && ir) begin
                if (choose) begin
                    b.d = sext_half(in_data[15:0]);  b.lane = 1'b0; b.last = 1'b0; q.push_back(b);
                    b.d = sext_half(in_data[31:16]); b.lane = 1'b1; b.last = 1'b1; q.push_back(b);
                end else begin
                    b.d = in_data; b.lane = 1'b0; b.last = 1'b1; q.push_back(b);
                end
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_ready()));
            if (q.size() != 0) begin
                chk("out_data", out_data, q[0].d);
                chk("out_lane", 32'(out_lane), 32'(q[0].lane));
                chk("out_last", 32'(out_last), 32'(q[0].last));
            end
`ifdef UNPACK_BEAT_COUNT_EN
            chk("beat_count", 32'(beat_count), 32'(exp_cnt));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        choose   = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        step();

        // Packed lane split
        choose = 1'b1; in_data = 32'hFFFE_0003; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("split_lo_data", out_data, 32'h0000_0003);
        chk("split_lo_lane", 32'(out_lane), 32'd0);
        chk("split_lo_last", 32'(out_last), 32'd0);
        step();
        @(negedge clk);
        chk("split_hi_data", out_data, 32'hFFFF_FFFE);
        chk("split_hi_lane", 32'(out_lane), 32'd1);
        chk("split_hi_last", 32'(out_last), 32'd1);
        step();

        // Full-width back-to-back
        choose = 1'b0; in_data = 32'h8000_0001; in_valid = 1'b1;
        step();
        in_data = 32'h0000_0005;
        @(negedge clk);
        chk("b2b_first", out_data, 32'h8000_0001);
        chk("b2b_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second", out_data, 32'h0000_0005);
        chk("b2b_last", 32'(out_last), 32'd1);
        step();

        // Backpressure
        choose = 1'b1; in_data = 32'h7FFF_8000; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_data", out_data, 32'hFFFF_8000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_hi_data", out_data, 32'h0000_7FFF);
        chk("bp_hi_lane", 32'(out_lane), 32'd1);
        step();

        // Mode switch with mid-emit toggle
        choose = 1'b1; in_data = 32'h0001_0002; in_valid = 1'b1;
        step();
        choose = 1'b0; in_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("ms_beat1", out_data, 32'h0000_0002);
        chk("ms_ready_lo", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("ms_beat2", out_data, 32'h0000_0001);
        chk("ms_beat2_lane", 32'(out_lane), 32'd1);
        step();
        in_valid = 1'b0; choose = 1'b1;
        @(negedge clk);
        chk("ms_beat3", out_data, 32'hFFFF_FFFF);
        chk("ms_beat3_last", 32'(out_last), 32'd1);
        step();

        // Mid-word reset
        choose = 1'b1; in_data = 32'h1234_5678; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mr_lo", out_data, 32'h0000_5678);
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("mr_valid_in_rst", 32'(out_valid), 32'd0);
        chk("mr_ready_in_rst", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_release_ready", 32'(in_ready), 32'd1);
        step();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mr_no_hi", 32'(out_valid), 32'd0);
            step();
        end

        // Randomized traffic, the model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            choose    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: in_data = 32'h8000_8000;
                1: in_data = 32'h7FFF_7FFF;
                2: in_data = 32'hFFFF_FFFF;
                3: in_data = 32'h0000_0000;
                default: in_data = $urandom;
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

`ifdef UNPACK_BEAT_COUNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; choose = 1'b0; in_data = 32'h0000_00A5; in_valid = 1'b1; out_ready = 1'b1;
        step();
        repeat (65537) step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("beat_count_wrap", 32'(beat_count), 32'd1);
        step();
        repeat (3) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
